// File: rtl/cu_seq.sv
// rtl/cu_seq.sv - multi-cycle control sequencer with call/return stack and memory watchdog
module cu_seq #(
    parameter int INSTR_W     = 16,
    parameter int PC_W        = 5,
    parameter int FLAG_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               instr_valid,
    output logic                               instr_ready,
    input  logic [INSTR_W-1:0]                 instr,
    input  logic [PC_W-1:0]                    pc_cur,
    input  logic [FLAG_W-1:0]                  flags,
    input  logic                               mem_ack,
    output logic                               reg_write,
    output logic [3:0]                         alu_op,
    output logic                               mem_read,
    output logic                               mem_write,
    output logic                               pc_inc,
    output logic                               pc_load,
    output logic [PC_W-1:0]                    pc_target,
    output logic                               hlt,
    output logic                               fault,
    output logic [1:0]                         fault_code,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int T_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [T_W-1:0] TIMER_LAST = T_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic [1:0] FC_OVF = 2'b01, FC_UNF = 2'b10, FC_TMO = 2'b11;

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM_WAIT, S_HALT, S_FAULT} state_t;

    state_t             state, state_nxt;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    ret_addr;
    logic [PC_W-1:0]    stack_mem [STACK_DEPTH];
    logic [LVL_W-1:0]   level;
    logic [T_W-1:0]     timer;
    logic [1:0]         fault_code_q, fault_code_nxt;
    logic               fault_now, push, pop;

    logic [3:0]      opcode, cond;
    logic [PC_W-1:0] ir_target;
    logic [IDX_W-1:0] push_idx, pop_idx;
    logic            is_lod;
    logic            unused_ir_bits;

    assign opcode         = ir[INSTR_W-1 -: 4];
    assign cond           = ir[INSTR_W-5 -: 4];
    assign ir_target      = ir[PC_W-1:0];
    assign is_lod         = (opcode == 4'b1110);
    assign push_idx       = IDX_W'(level);
    assign pop_idx        = IDX_W'(level - LVL_W'(1));
    assign unused_ir_bits = ^ir[INSTR_W-9:PC_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            ir           <= '0;
            ret_addr     <= '0;
            level        <= '0;
            timer        <= '0;
            fault_code_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && instr_valid) begin
                ir       <= instr;
                ret_addr <= pc_cur + PC_W'(1);
            end
            if (push)
                level <= level + LVL_W'(1);
            else if (pop)
                level <= level - LVL_W'(1);
            timer <= (state == S_MEM_WAIT && !mem_ack) ? timer + T_W'(1) : '0;
            if (fault_now)
                fault_code_q <= fault_code_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            stack_mem[push_idx] <= ret_addr;
    end

    // Outputs are forced low while reset is held so an aborted access issues no strobes.
    always_comb begin
        state_nxt      = state;
        instr_ready    = 1'b0;
        reg_write      = 1'b0;
        alu_op         = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        pc_inc         = 1'b0;
        pc_load        = 1'b0;
        pc_target      = '0;
        hlt            = 1'b0;
        fault          = 1'b0;
        fault_code     = '0;
        stack_level    = '0;
        fault_now      = 1'b0;
        fault_code_nxt = '0;
        push           = 1'b0;
        pop            = 1'b0;
        if (rst_n) begin
            stack_level = level;
            case (state)
                S_FETCH: begin
                    instr_ready = 1'b1;
                    if (instr_valid)
                        state_nxt = S_EXEC;
                end
                S_EXEC: begin
                    state_nxt = S_FETCH;
                    case (opcode)
                        4'b0000: begin
                            hlt       = 1'b1;
                            state_nxt = S_HALT;
                        end
                        4'b1011: begin
                            pc_load   = 1'b1;
                            pc_target = ir_target;
                        end
                        4'b1100: begin
                            if (!cond[3]) begin
                                pc_load   = flags[cond[2:0]];
                                pc_inc    = !flags[cond[2:0]];
                                pc_target = flags[cond[2:0]] ? ir_target : '0;
                            end else begin
                                case (cond[2:0])
                                    3'b000: begin
                                        pc_load   = 1'b1;
                                        pc_target = ir_target;
                                    end
                                    3'b001: begin
                                        if (level == LVL_W'(STACK_DEPTH)) begin
                                            fault_now      = 1'b1;
                                            fault_code_nxt = FC_OVF;
                                        end else begin
                                            push      = 1'b1;
                                            pc_load   = 1'b1;
                                            pc_target = ir_target;
                                        end
                                    end
                                    3'b010: begin
                                        if (level == '0) begin
                                            fault_now      = 1'b1;
                                            fault_code_nxt = FC_UNF;
                                        end else begin
                                            pop       = 1'b1;
                                            pc_load   = 1'b1;
                                            pc_target = stack_mem[pop_idx];
                                        end
                                    end
                                    default: pc_inc = 1'b1;
                                endcase
                            end
                        end
                        4'b1110: begin
                            mem_read  = 1'b1;
                            state_nxt = S_MEM_WAIT;
                        end
                        4'b1111: begin
                            mem_write = 1'b1;
                            state_nxt = S_MEM_WAIT;
                        end
                        default: begin
                            alu_op    = opcode;
                            reg_write = (opcode != 4'b1101);
                            pc_inc    = 1'b1;
                        end
                    endcase
                end
                S_MEM_WAIT: begin
                    mem_read  = is_lod;
                    mem_write = !is_lod;
                    if (mem_ack) begin
                        pc_inc    = 1'b1;
                        reg_write = is_lod;
                        state_nxt = S_FETCH;
                    end else if (MEM_TIMEOUT != 0 && timer == TIMER_LAST) begin
                        fault_now      = 1'b1;
                        fault_code_nxt = FC_TMO;
                    end
                end
                S_HALT:  hlt = 1'b1;
                S_FAULT: begin
                    fault      = 1'b1;
                    fault_code = fault_code_q;
                end
                default: state_nxt = S_FETCH;
            endcase
            if (fault_now) begin
                fault      = 1'b1;
                fault_code = fault_code_nxt;
                state_nxt  = S_FAULT;
            end
        end
    end
endmodule

// File: tb/tb_cu_seq.sv
// tb/tb_cu_seq.sv - vector table, randomized model comparison and corner sequences for cu_seq
module tb_cu_seq;
    localparam int SD = 4;
    localparam int MT = 3;
    localparam int NX_FETCH = 0, NX_MEM = 1, NX_HALT = 2, NX_FAULT = 3;

    typedef struct packed {
        logic       rdy;
        logic       rw;
        logic [3:0] alu;
        logic       mr;
        logic       mw;
        logic       inc;
        logic       ld;
        logic [4:0] tgt;
        logic       hlt;
        logic       flt;
        logic [1:0] fc;
        logic [2:0] lvl;
    } exp_t;

    typedef struct {
        logic [15:0] ins;
        logic [4:0]  pc;
        logic [7:0]  fl;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, mem_ack = 1'b0;
    logic [15:0] instr = '0;
    logic [4:0]  pc_cur = '0;
    logic [7:0]  flags = '0;
    logic        instr_ready, reg_write, mem_read, mem_write, pc_inc, pc_load, hlt, fault;
    logic [3:0]  alu_op;
    logic [4:0]  pc_target;
    logic [1:0]  fault_code;
    logic [2:0]  stack_level;
    exp_t        outs;
    int          n_vec = 0, n_err = 0;
    logic [4:0]  stk[$];

    cu_seq #(.INSTR_W(16), .PC_W(5), .FLAG_W(8), .STACK_DEPTH(SD), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc_cur(pc_cur), .flags(flags), .mem_ack(mem_ack),
        .reg_write(reg_write), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target), .hlt(hlt),
        .fault(fault), .fault_code(fault_code), .stack_level(stack_level)
    );

    always #5 clk = ~clk;

    assign outs = {instr_ready, reg_write, alu_op, mem_read, mem_write, pc_inc, pc_load,
                   pc_target, hlt, fault, fault_code, stack_level};

    function automatic string fmt(exp_t v);
        return $sformatf("rdy=%b rw=%b alu=%h mr=%b mw=%b inc=%b ld=%b tgt=%h hlt=%b flt=%b fc=%b lvl=%0d",
                         v.rdy, v.rw, v.alu, v.mr, v.mw, v.inc, v.ld, v.tgt, v.hlt, v.flt, v.fc, v.lvl);
    endfunction

    function automatic exp_t ex(logic [3:0] alu, logic rw, logic inc, logic ld, logic [4:0] tgt);
        exp_t e = '0;
        e.alu = alu; e.rw = rw; e.inc = inc; e.ld = ld; e.tgt = tgt;
        return e;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual {%s} expected {%s}", name, $time, fmt(act), fmt(exp));
        end
    endtask

    // Instruction-level reference: what one EXEC cycle should show, plus the stack effect.
    task automatic model_exec(input logic [15:0] ins, input logic [4:0] pc, input logic [7:0] fl,
                              output exp_t e, output int nxt);
        logic [3:0] op, c;
        logic [4:0] ra;
        op  = ins[15:12];
        c   = ins[11:8];
        ra  = pc + 5'd1;
        e   = '0;
        e.lvl = 3'(stk.size());
        nxt = NX_FETCH;
        if (op == 4'h0) begin
            e.hlt = 1'b1; nxt = NX_HALT;
        end else if (op <= 4'hA || op == 4'hD) begin
            e.alu = op; e.rw = (op != 4'hD); e.inc = 1'b1;
        end else if (op == 4'hB) begin
            e.ld = 1'b1; e.tgt = ins[4:0];
        end else if (op >= 4'hE) begin
            e.mr = (op == 4'hE); e.mw = (op == 4'hF); nxt = NX_MEM;
        end else if (c <= 4'h8) begin
            if (c == 4'h8 || fl[c[2:0]]) begin e.ld = 1'b1; e.tgt = ins[4:0]; end
            else e.inc = 1'b1;
        end else if (c == 4'h9) begin
            if (stk.size() == SD) begin e.flt = 1'b1; e.fc = 2'b01; nxt = NX_FAULT; end
            else begin stk.push_back(ra); e.ld = 1'b1; e.tgt = ins[4:0]; end
        end else if (c == 4'hA) begin
            if (stk.size() == 0) begin e.flt = 1'b1; e.fc = 2'b10; nxt = NX_FAULT; end
            else begin e.ld = 1'b1; e.tgt = stk.pop_back(); end
        end else begin
            e.inc = 1'b1;
        end
    endtask

    task automatic present(input logic [15:0] ins, input logic [4:0] pc, input logic [7:0] fl,
                           input string name);
        exp_t idle;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        idle = '0; idle.rdy = 1'b1; idle.lvl = 3'(stk.size());
        check({name, "/fetch"}, outs, idle);
        instr = ins; pc_cur = pc; flags = fl; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0; instr = 16'($urandom); pc_cur = 5'($urandom);
        #1;
    endtask

    task automatic apply_model(input logic [15:0] ins, input logic [4:0] pc, input logic [7:0] fl,
                               input int ack_at, input string name);
        exp_t       e;
        int         nxt;
        logic [2:0] lvl;
        logic [1:0] code;
        present(ins, pc, fl, name);
        model_exec(ins, pc, fl, e, nxt);
        check({name, "/exec"}, outs, e);
        lvl  = 3'(stk.size());
        code = e.fc;
        if (nxt == NX_MEM) begin
            for (int k = 0; k < MT; k++) begin
                @(negedge clk);
                mem_ack = (k == ack_at);
                #1;
                e = '0; e.lvl = lvl; e.mr = (ins[15:12] == 4'hE); e.mw = !e.mr;
                if (mem_ack) begin
                    e.inc = 1'b1; e.rw = e.mr;
                end else if (k == MT - 1) begin
                    e.flt = 1'b1; e.fc = 2'b11; nxt = NX_FAULT; code = 2'b11;
                end
                check($sformatf("%s/wait%0d", name, k), outs, e);
                if (mem_ack) break;
            end
        end
        if (nxt == NX_HALT || nxt == NX_FAULT) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                mem_ack = 1'b0; instr_valid = 1'b1;
                #1;
                e = '0; e.lvl = lvl; e.hlt = (nxt == NX_HALT); e.flt = (nxt == NX_FAULT);
                e.fc = (nxt == NX_FAULT) ? code : 2'b00;
                check($sformatf("%s/term%0d", name, k), outs, e);
            end
            instr_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
        #1;
        check({name, "/rst_now"}, outs, '0);
        @(negedge clk);
        #1;
        check({name, "/rst_hold"}, outs, '0);
        rst_n = 1'b1;
        stk.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
        $fatal(1);
    end

    initial begin
        vec_t tbl[12];
        exp_t e;
        int   nxt;
        tbl[0]  = '{16'h1123, 5'h00, 8'h00, ex(4'h1, 1, 1, 0, 5'h00)};
        tbl[1]  = '{16'hC015, 5'h01, 8'h01, ex(4'h0, 0, 0, 1, 5'h15)};
        tbl[2]  = '{16'hC015, 5'h02, 8'h00, ex(4'h0, 0, 1, 0, 5'h00)};
        tbl[3]  = '{16'hD123, 5'h03, 8'hFF, ex(4'hD, 0, 1, 0, 5'h00)};
        tbl[4]  = '{16'hB01C, 5'h04, 8'h00, ex(4'h0, 0, 0, 1, 5'h1C)};
        tbl[5]  = '{16'hC707, 5'h05, 8'h80, ex(4'h0, 0, 0, 1, 5'h07)};
        tbl[6]  = '{16'hC803, 5'h06, 8'h00, ex(4'h0, 0, 0, 1, 5'h03)};
        tbl[7]  = '{16'hCB03, 5'h07, 8'hFF, ex(4'h0, 0, 1, 0, 5'h00)};
        tbl[8]  = '{16'h9FFF, 5'h08, 8'h00, ex(4'h9, 1, 1, 0, 5'h00)};
        tbl[9]  = '{16'hC612, 5'h09, 8'hBF, ex(4'h0, 0, 1, 0, 5'h00)};
        tbl[10] = '{16'hA5E7, 5'h0A, 8'h00, ex(4'hA, 1, 1, 0, 5'h00)};
        tbl[11] = '{16'hCF1F, 5'h0B, 8'hFF, ex(4'h0, 0, 1, 0, 5'h00)};

        do_reset("init");
        foreach (tbl[i]) begin
            present(tbl[i].ins, tbl[i].pc, tbl[i].fl, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d", i), outs, tbl[i].e);
        end

        for (int i = 0; i < 150; i++) begin
            logic [3:0] op, c;
            op = 4'($urandom_range(1, 15));
            c  = 4'($urandom);
            if (op == 4'hC && c == 4'h9 && stk.size() == SD) c = 4'hB;
            if (op == 4'hC && c == 4'hA && stk.size() == 0)  c = 4'hB;
            apply_model({op, c, 8'($urandom)}, 5'($urandom), 8'($urandom),
                        $urandom_range(0, MT - 1), $sformatf("rnd%0d", i));
        end

        do_reset("pre_stack");
        apply_model(16'hC90A, 5'h1F, 8'h00, 0, "cal_wrap");
        apply_model(16'hCA00, 5'h0A, 8'h00, 0, "ret_wrap");
        for (int i = 0; i < SD; i++)
            apply_model(16'hC910 + 16'(i), 5'(i * 3), 8'h00, 0, $sformatf("cal_fill%0d", i));
        apply_model(16'hC91E, 5'h11, 8'h00, 0, "cal_ovf");
        do_reset("after_ovf");
        apply_model(16'hCA00, 5'h02, 8'hFF, 0, "ret_unf");
        do_reset("after_unf");

        apply_model(16'hE005, 5'h03, 8'h00, 2, "lod_ack_expiry");
        apply_model(16'hF006, 5'h04, 8'h00, 0, "str_ack_now");
        apply_model(16'hE007, 5'h05, 8'h00, 99, "lod_timeout");
        do_reset("after_tmo");
        apply_model(16'h0000, 5'h06, 8'h00, 0, "hlt");
        do_reset("after_hlt");

        present(16'hE123, 5'h07, 8'h00, "lod_rst");
        model_exec(16'hE123, 5'h07, 8'h00, e, nxt);
        check("lod_rst/exec", outs, e);
        @(negedge clk);
        #1;
        e = '0; e.mr = 1'b1;
        check("lod_rst/wait0", outs, e);
        do_reset("lod_rst");
        apply_model(16'h2345, 5'h08, 8'h00, 0, "post_rst_add");

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
